morse_frame_sequencer: RTL and testbench
========================================

Name: morse_frame_sequencer

Overview:
- Sequencer that sits in front of `sequence_translator`.
- Collects 10-bit Morse codes one per handshake from the upstream symbol decoder and packs up to 16 of them into a 160-bit frame.
- Presents the frame to the translator, waits a fixed settle time, then captures the 128-bit character result.
- Streams the valid characters out one byte at a time over a valid/ready handshake.

Parameters:
- CODE_W, 10, width of one Morse code (5 symbols × 2 bits: 00 dot, 01 dash, 11 empty, 10 word-space prefix).
- SLOTS, 16, codes per frame; frame width = SLOTS*CODE_W, result width = SLOTS*8.
- SETTLE_CYCLES, 2, clock edges `frame_sequences` is held before `translated_characters` is captured (≥1).
- PAD_CODE, 10'h3FF, code written into unused slots; the translator maps it to 0x00.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `seq_in`  in  CODE_W  code from the decoder.
- `seq_valid`  in  1  `seq_in` is valid.
- `seq_ready`  out  1  sequencer accepts a code this cycle.
- `flush`  in  1  single-cycle pulse: end of message, launch the partial frame.
- `frame_sequences`  out  SLOTS*CODE_W  frame to the translator `sequences` input.
- `translated_characters`  in  SLOTS*8  translator result.
- `char_out`  out  8  ASCII character.
- `char_valid`  out  1  `char_out` is valid.
- `char_ready`  in  1  downstream accepts a character.
- `char_last`  out  1  current character is the final one of the frame.
- `busy`  out  1  frame in flight (any state other than FILL).
- `frame_count`  out  8  frames completed, wraps 255→0.

Behaviour:
- Reset (async, `rst_n`=0):
  - state=FILL, slot count=0, staging register all PAD_CODE.
  - `frame_sequences`=all ones.
  - `char_out`=0, `char_valid`=0, `char_last`=0, `busy`=0, `frame_count`=0.
  - `seq_ready`=0 while `rst_n`=0.
- State FILL:
  - `seq_ready` = (count<SLOTS), combinational.
  - On `seq_valid`&&`seq_ready`: write the code into slot[count] at bits [SLOTS*CODE_W-1-count*CODE_W -: CODE_W] (slot 0 is the MSBs), then count++.
  - Go to LAUNCH when the SLOTS-th code is accepted, or when `flush`=1 and count>0 after that cycle's accept. This includes `flush` arriving in the same cycle as a code.
  - `flush` with count=0 and no accept is ignored.
- State LAUNCH (1 cycle):
  - At the edge, `frame_sequences` <= staging, settle counter=0, go to SETTLE.
  - `frame_sequences` changes only at this edge; it is otherwise held stable.
- State SETTLE:
  - Counter increments each edge.
  - After SETTLE_CYCLES edges: capture `translated_characters` into the result register, `frame_count`++, byte index=0, go to DRAIN.
  - `char_valid`=1 from this edge onward.
- State DRAIN:
  - `char_out` = result byte [SLOTS*8-1-idx*8 -: 8], i.e. the first code's character comes from the MSBs.
  - `char_last` = (idx==count-1).
  - On `char_valid`&&`char_ready`: idx++.
  - On the last handshake: `char_valid`=0, `char_last`=0, count=0, staging all PAD_CODE, go to FILL.
  - Padding bytes are never emitted.
  - `char_out` and `char_last` hold stable while `char_valid`=1 and `char_ready`=0.
- While not in FILL:
  - `seq_ready`=0.
  - `seq_valid` and `flush` are ignored (no buffering).
- Latency: the first `char_valid` rises SETTLE_CYCLES+2 edges after the accepting/flush edge (4 with defaults).
- A user-supplied PAD_CODE counts as a slot and emits 0x00.
- Async reset mid-operation aborts the frame; the next frame after release behaves normally.

Test Plan:
- Reset check: assert `rst_n`=0 mid-stream -> all outputs at reset values immediately, without a clock edge; after release `seq_ready`=1 and `busy`=0.
- Full frame: 16 × 10'b0001111111 ('A') back-to-back with `char_ready`=1:
  - `frame_sequences` = 16 copies of 10'b0001111111.
  - First `char_valid` 4 edges after the 16th accept.
  - 16 bytes of 0x41, `char_last` only on the 16th, `frame_count`=1.
- Partial frame: codes 10'b0000001111, 10'b0101011111, 10'b0000001111, then `flush`:
  - `frame_sequences`[159:130] holds the three codes, [129:0] all ones.
  - Output 0x53, 0x4F, 0x53 ("SOS"), `char_last` on the third.
- Flush in the same cycle as the 3rd code -> 3-slot frame launched, one frame only. `flush` in FILL with count=0 -> no state change, `busy` stays 0.
- Backpressure: toggle `char_ready` randomly during DRAIN -> each byte held until handshake, no loss or duplication. Hold `seq_valid`=1 during DRAIN -> `seq_ready`=0, code not absorbed until FILL.
- Wrap: run 256 frames -> `frame_count` returns to 0. Space code 10'b1011111111 inside a frame -> 0x20 emitted in sequence.

Source files
------------

// File: rtl/morse_frame_sequencer.sv
// Morse frame sequencer: packs decoded Morse codes into a frame for the
// downstream translator, waits for its result to settle, then streams the
// translated characters out one byte at a time.
module morse_frame_sequencer #(
  parameter int                CODE_W        = 10,
  parameter int                SLOTS         = 16,
  parameter int                SETTLE_CYCLES = 2,
  parameter logic [CODE_W-1:0] PAD_CODE      = 10'h3FF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CODE_W-1:0]         seq_in,
  input  logic                      seq_valid,
  output logic                      seq_ready,
  input  logic                      flush,
  output logic [SLOTS*CODE_W-1:0]   frame_sequences,
  input  logic [SLOTS*8-1:0]        translated_characters,
  output logic [7:0]                char_out,
  output logic                      char_valid,
  input  logic                      char_ready,
  output logic                      char_last,
  output logic                      busy,
  output logic [7:0]                frame_count
);

  localparam int FRAME_W = SLOTS * CODE_W;
  localparam int RES_W   = SLOTS * 8;
  localparam int CNT_W   = $clog2(SLOTS + 1);
  localparam int IDX_W   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    SETTLE = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [FRAME_W-1:0] staging_q, staging_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic [7:0]         fcount_q, fcount_d;

  logic               accept;
  logic [CNT_W-1:0]   count_acc;
  logic               at_last;
  logic [7:0]         result_bytes [SLOTS];

  // Slot 0 of the result sits in the MSBs; split it into addressable bytes.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_bytes
    assign result_bytes[gi] = result_q[RES_W-1-gi*8 -: 8];
  end

  // Handshake and flag decode; reset forces seq_ready low immediately.
  assign seq_ready = rst_n && (state_q == FILL) && (count_q < CNT_W'(SLOTS));
  assign accept    = seq_ready && seq_valid;
  assign count_acc = count_q + {{(CNT_W-1){1'b0}}, accept};
  assign at_last   = (CNT_W'(idx_q) == (count_q - 1'b1));

  assign frame_sequences = frame_q;
  assign char_valid      = valid_q;
  assign char_out        = valid_q ? result_bytes[idx_q] : 8'h00;
  assign char_last       = valid_q && at_last;
  assign busy            = (state_q != FILL);
  assign frame_count     = fcount_q;

  // Next-state and datapath updates for fill / launch / settle / drain.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    staging_d = staging_q;
    frame_d   = frame_q;
    settle_d  = settle_q;
    result_d  = result_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    fcount_d  = fcount_q;

    case (state_q)
      FILL: begin
        if (accept) begin
          for (int i = 0; i < SLOTS; i++) begin
            if (count_q == CNT_W'(i)) begin
              staging_d[FRAME_W-1-i*CODE_W -: CODE_W] = seq_in;
            end
          end
          count_d = count_acc;
        end
        // A flush that coincides with a code still launches that code.
        if ((count_acc == CNT_W'(SLOTS)) || (flush && (count_acc != '0))) begin
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        frame_d  = staging_q;
        settle_d = '0;
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYCLES)) begin
          result_d = translated_characters;
          fcount_d = fcount_q + 8'd1;
          idx_d    = '0;
          valid_d  = 1'b1;
          state_d  = DRAIN;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      DRAIN: begin
        if (valid_q && char_ready) begin
          if (at_last) begin
            valid_d   = 1'b0;
            count_d   = '0;
            staging_d = {SLOTS{PAD_CODE}};
            state_d   = FILL;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      count_q   <= '0;
      staging_q <= {SLOTS{PAD_CODE}};
      frame_q   <= '1;
      settle_q  <= '0;
      result_q  <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      fcount_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      staging_q <= staging_d;
      frame_q   <= frame_d;
      settle_q  <= settle_d;
      result_q  <= result_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      fcount_q  <= fcount_d;
    end
  end

endmodule

// File: tb/tb_morse_frame_sequencer.sv
// Scoreboard bench for morse_frame_sequencer with a behavioural translator.
module tb_morse_frame_sequencer;

  localparam logic [9:0] C_A  = 10'b0001111111;
  localparam logic [9:0] C_S  = 10'b0000001111;
  localparam logic [9:0] C_O  = 10'b0101011111;
  localparam logic [9:0] C_SP = 10'b1011111111;
  localparam logic [9:0] C_PD = 10'h3FF;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [9:0]   seq_in;
  logic         seq_valid;
  logic         seq_ready;
  logic         flush;
  logic [159:0] frame_sequences;
  logic [127:0] translated_characters;
  logic [7:0]   char_out;
  logic         char_valid;
  logic         char_ready;
  logic         char_last;
  logic         busy;
  logic [7:0]   frame_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0] ch;
    logic       last;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  logic [9:0] code_buf [16];
  logic [7:0] char_buf [16];
  logic [9:0] tbl_code [5];
  logic [7:0] tbl_char [5];

  logic rand_ready, ready_hold, rnd_bit;
  logic hold_pending = 1'b0;
  logic [7:0] held_char;
  logic held_last;
  int lat;

  always #5 clk = ~clk;

  assign char_ready = rand_ready ? rnd_bit : ready_hold;

  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  // Behavioural translator: one lookup per slot, result slot 0 in the MSBs.
  function automatic logic [7:0] xlate(input logic [9:0] c);
    case (c)
      10'b0001111111: return 8'h41;
      10'b0000001111: return 8'h53;
      10'b0101011111: return 8'h4F;
      10'b1011111111: return 8'h20;
      10'h3FF:        return 8'h00;
      default:        return 8'h3F;
    endcase
  endfunction

  for (genvar gi = 0; gi < 16; gi++) begin : g_xl
    assign translated_characters[127-gi*8 -: 8] = xlate(frame_sequences[159-gi*10 -: 10]);
  end

  morse_frame_sequencer dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .seq_in                (seq_in),
    .seq_valid             (seq_valid),
    .seq_ready             (seq_ready),
    .flush                 (flush),
    .frame_sequences       (frame_sequences),
    .translated_characters (translated_characters),
    .char_out              (char_out),
    .char_valid            (char_valid),
    .char_ready            (char_ready),
    .char_last             (char_last),
    .busy                  (busy),
    .frame_count           (frame_count)
  );

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each handshake, checks hold stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pending = 1'b0;
    end else begin
      if (char_valid && hold_pending) begin
        check("hold_char", 160'(char_out), 160'(held_char));
        check("hold_last", 160'(char_last), 160'(held_last));
      end
      if (char_valid && char_ready) begin
        check("q_nonempty", 160'(exp_q.size() != 0), 160'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          $display("char %02h last %0b (exp %02h/%0b) frames %0d", char_out, char_last, e.ch, e.last, frame_count);
          check("char_out", 160'(char_out), 160'(e.ch));
          check("char_last", 160'(char_last), 160'(e.last));
        end
      end
      hold_pending = char_valid && !char_ready;
      held_char    = char_out;
      held_last    = char_last;
    end
  end

  task automatic check_reset_outputs();
    check("rst_seq_ready", 160'(seq_ready), 160'(0));
    check("rst_frame", frame_sequences, {160{1'b1}});
    check("rst_char_out", 160'(char_out), 160'(0));
    check("rst_char_valid", 160'(char_valid), 160'(0));
    check("rst_char_last", 160'(char_last), 160'(0));
    check("rst_busy", 160'(busy), 160'(0));
    check("rst_frame_count", 160'(frame_count), 160'(0));
  endtask

  // fmode 0: flush after last code, 1: flush with last code, 2: no flush.
  task automatic send_frame(input int n, input int fmode);
    for (int i = 0; i < n; i++) exp_q.push_back({char_buf[i], (i == n - 1)});
    for (int i = 0; i < n; i++) begin
      seq_in    = code_buf[i];
      seq_valid = 1'b1;
      if (fmode == 1 && i == n - 1) flush = 1'b1;
      @(negedge clk);
      for (int t = 0; t < 500 && !seq_ready; t++) @(negedge clk);
      if (!seq_ready) check("accept_timeout", 160'(seq_ready), 160'(1));
      @(posedge clk); #1;
    end
    seq_valid = 1'b0;
    flush     = 1'b0;
    if (fmode == 0) begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
    end
  endtask

  task automatic wait_idle();
    @(negedge clk);
    for (int t = 0; t < 3000 && busy; t++) @(negedge clk);
    if (busy) check("idle_timeout", 160'(busy), 160'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    tbl_code[0] = C_A;  tbl_char[0] = 8'h41;
    tbl_code[1] = C_S;  tbl_char[1] = 8'h53;
    tbl_code[2] = C_O;  tbl_char[2] = 8'h4F;
    tbl_code[3] = C_SP; tbl_char[3] = 8'h20;
    tbl_code[4] = C_PD; tbl_char[4] = 8'h00;

    rst_n = 1'b0; seq_in = '0; seq_valid = 1'b0; flush = 1'b0;
    rand_ready = 1'b0; ready_hold = 1'b1;
    #12;
    check_reset_outputs();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", 160'(seq_ready), 160'(1));
    check("post_rst_busy", 160'(busy), 160'(0));

    // Full frame of 16 'A' codes, no flush.
    for (int i = 0; i < 16; i++) begin code_buf[i] = C_A; char_buf[i] = 8'h41; end
    send_frame(16, 2);
    lat = 0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) check("frame_full", frame_sequences, {16{C_A}});
      if (char_valid) lat = k;
    end
    check("first_valid_latency", 160'(lat), 160'(4));
    wait_idle();
    check("fc_full", 160'(frame_count), 160'(1));

    // Partial frame "SOS" with a separate flush.
    code_buf[0] = C_S; code_buf[1] = C_O; code_buf[2] = C_S;
    char_buf[0] = 8'h53; char_buf[1] = 8'h4F; char_buf[2] = 8'h53;
    send_frame(3, 0);
    wait_idle();
    check("frame_sos_hi", 160'(frame_sequences[159:130]), 160'({C_S, C_O, C_S}));
    check("frame_sos_lo", 160'(frame_sequences[129:0]), 160'({130{1'b1}}));
    check("fc_sos", 160'(frame_count), 160'(2));

    // Flush with an empty frame is ignored.
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("empty_flush_busy", 160'(busy), 160'(0));
    @(posedge clk); #1;
    check("empty_flush_busy2", 160'(busy), 160'(0));
    check("fc_empty_flush", 160'(frame_count), 160'(2));

    // Flush together with the third code.
    code_buf[0] = C_A; code_buf[1] = C_SP; code_buf[2] = C_A;
    char_buf[0] = 8'h41; char_buf[1] = 8'h20; char_buf[2] = 8'h41;
    send_frame(3, 1);
    wait_idle();
    check("frame_same_cycle", 160'(frame_sequences[159:130]), 160'({C_A, C_SP, C_A}));
    check("fc_same_cycle", 160'(frame_count), 160'(3));
    @(posedge clk); #1;
    check("one_frame_only", 160'(busy), 160'(0));

    // Random backpressure, with a code held at the input during drain.
    rand_ready = 1'b1;
    code_buf[0] = C_S; code_buf[1] = C_O; code_buf[2] = C_S; code_buf[3] = C_A; code_buf[4] = C_SP;
    char_buf[0] = 8'h53; char_buf[1] = 8'h4F; char_buf[2] = 8'h53; char_buf[3] = 8'h41; char_buf[4] = 8'h20;
    send_frame(5, 0);
    seq_in = C_S; seq_valid = 1'b1;
    exp_q.push_back({8'h53, 1'b1});
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (!busy) break;
      check("ready_in_drain", 160'(seq_ready), 160'(0));
    end
    if (busy) check("drain_timeout", 160'(busy), 160'(0));
    check("ready_back", 160'(seq_ready), 160'(1));
    @(posedge clk); #1;
    seq_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_idle();
    rand_ready = 1'b0;
    check("fc_backpressure", 160'(frame_count), 160'(5));

    // Single-code frames until the frame counter wraps.
    for (int f = 0; f < 251; f++) begin
      code_buf[0] = tbl_code[f % 5];
      char_buf[0] = tbl_char[f % 5];
      send_frame(1, 1);
    end
    wait_idle();
    check("fc_wrap", 160'(frame_count), 160'(0));

    // Asynchronous reset while a character is waiting.
    ready_hold = 1'b0;
    code_buf[0] = C_S; code_buf[1] = C_O; code_buf[2] = C_S;
    char_buf[0] = 8'h53; char_buf[1] = 8'h4F; char_buf[2] = 8'h53;
    send_frame(3, 1);
    @(negedge clk);
    for (int t = 0; t < 50 && !char_valid; t++) @(negedge clk);
    check("valid_before_reset", 160'(char_valid), 160'(1));
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    #10 rst_n = 1'b1;
    ready_hold = 1'b1;
    @(posedge clk); #1;
    check("rel_ready", 160'(seq_ready), 160'(1));
    check("rel_busy", 160'(busy), 160'(0));
    send_frame(3, 0);
    wait_idle();
    check("fc_after_reset", 160'(frame_count), 160'(1));
    check("q_empty", 160'(exp_q.size()), 160'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
